// File: rtl/alu_sched_pkg.sv
// Shared ALU opcodes and scheduler FSM encoding.
// Imported by alu_core and alu_rr_scheduler.
package alu_sched_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU, all arithmetic modulo 2^DATA_W.
// ALU_FLAGS_EN adds a carry/borrow output.
module alu_core
  import alu_sched_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result
`ifdef ALU_FLAGS_EN
  ,
  output logic              carry
`endif
);

`ifdef ALU_FLAGS_EN
  localparam int SW = DATA_W + 1;
`else
  localparam int SW = DATA_W;
`endif

  logic [SW-1:0] sum;

  assign sum = SW'(a) + SW'(b);

  // Opcode decode; undefined opcodes yield zero
  always_comb begin
    result = '0;
    unique case (op)
      OP_ADD:  result = sum[DATA_W-1:0];
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      default: result = '0;
    endcase
  end

`ifdef ALU_FLAGS_EN
  // Carry-out for ADD, borrow for SUB, else 0
  always_comb begin
    carry = 1'b0;
    unique case (op)
      OP_ADD:  carry = sum[SW-1];
      OP_SUB:  carry = (a < b);
      default: carry = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one ALU among NUM_REQ requesters.
// ALU_FLAGS_EN adds registered rsp_carry / rsp_zero outputs.
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 8,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_op_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_op_b,
  input  logic [NUM_REQ*3-1:0]    req_alu_op,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_W-1:0]       rsp_result,
  output logic [ID_W-1:0]         rsp_id,
`ifdef ALU_FLAGS_EN
  output logic                    rsp_carry,
  output logic                    rsp_zero,
`endif
  output logic                    busy
);

  state_t            state;
  state_t            state_nx;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   pick_idx;
  logic [ID_W-1:0]   scan_idx;
  logic              pick_found;
  logic              grant;
  logic [ID_W-1:0]   cap_id;
  logic [DATA_W-1:0] cap_a;
  logic [DATA_W-1:0] cap_b;
  logic [2:0]        cap_op;
  logic [DATA_W-1:0] alu_res;
`ifdef ALU_FLAGS_EN
  logic              alu_carry;
`endif

  // Rotating-priority search starting after last_grant
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!pick_found && req_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  assign grant     = (state == IDLE) && pick_found && !rst;
  assign req_ready = grant ? (NUM_REQ'(1) << pick_idx) : '0;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (pick_found) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .a      (cap_a),
    .b      (cap_b),
    .op     (cap_op),
`ifdef ALU_FLAGS_EN
    .carry  (alu_carry),
`endif
    .result (alu_res)
  );

  // Operand capture on grant, result register in EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= ID_W'(NUM_REQ - 1);
      cap_id     <= '0;
      cap_a      <= '0;
      cap_b      <= '0;
      cap_op     <= '0;
      rsp_result <= '0;
      rsp_id     <= '0;
`ifdef ALU_FLAGS_EN
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
`endif
    end else begin
      if (grant) begin
        last_grant <= pick_idx;
        cap_id     <= pick_idx;
        cap_a      <= req_op_a[pick_idx*DATA_W +: DATA_W];
        cap_b      <= req_op_b[pick_idx*DATA_W +: DATA_W];
        cap_op     <= req_alu_op[pick_idx*3 +: 3];
      end
      if (state == EXEC) begin
        rsp_result <= alu_res;
        rsp_id     <= cap_id;
`ifdef ALU_FLAGS_EN
        rsp_carry  <= alu_carry;
        rsp_zero   <= (alu_res == '0);
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Randomized self-checking bench for alu_rr_scheduler.
// Checks against a transaction-level reference model.
module tb_alu_rr_scheduler;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_op_a;
  logic [N*W-1:0] req_op_b;
  logic [N*3-1:0] req_alu_op;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_result;
  logic [1:0]     rsp_id;
  logic           busy;
`ifdef ALU_FLAGS_EN
  logic           rsp_carry;
  logic           rsp_zero;
`endif

  alu_rr_scheduler #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op_a   (req_op_a),
    .req_op_b   (req_op_b),
    .req_alu_op (req_alu_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_id     (rsp_id),
`ifdef ALU_FLAGS_EN
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_g = N - 1;
  int prev_cyc = 0;

  logic [W-1:0] va [N];
  logic [W-1:0] vb [N];
  logic [2:0]   vo [N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bus();
    for (int i = 0; i < N; i++) begin
      req_op_a[i*W +: W] = va[i];
      req_op_b[i*W +: W] = vb[i];
      req_alu_op[i*3 +: 3] = vo[i];
    end
  endtask

  task automatic scramble();
    for (int i = 0; i < N; i++) begin
      va[i] = W'($urandom);
      vb[i] = W'($urandom);
      vo[i] = 3'($urandom);
    end
    drive_bus();
  endtask

  function automatic int ref_pick(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++)
      if (v[(last_g + k) % N]) return (last_g + k) % N;
    return -1;
  endfunction

  function automatic logic [8:0] ref_alu(input int a,
                                         input int b,
                                         input int op);
    int r;
    bit c;
    c = 1'b0;
    case (op)
      0: begin r = a + b; c = (r > 255); end
      1: begin r = a - b; c = (a < b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 255 - a;
      default: r = 0;
    endcase
    r = ((r % 256) + 256) % 256;
    return {c, 8'(r)};
  endfunction

  // Called at a negedge in IDLE; returns at the following IDLE negedge
  task automatic do_op(input logic [N-1:0] v,
                       input int bp,
                       input bit gap);
    int g;
    logic [8:0] e;
    logic [N-1:0] one;
    req_valid = v;
    drive_bus();
    #1;
    g = ref_pick(v);
    one = N'(1) << g;
    chk("grant", 32'(req_ready), 32'(one));
    if (gap) chk("gap", 32'(cyc - prev_cyc), 32'd3);
    prev_cyc = cyc;
    e = ref_alu(int'(va[g]), int'(vb[g]), int'(vo[g]));
    last_g = g;
    @(negedge clk);
    chk("exec_ready", 32'(req_ready), 32'd0);
    chk("exec_valid", 32'(rsp_valid), 32'd0);
    chk("exec_busy", 32'(busy), 32'd1);
    scramble();
    rsp_ready = 1'b0;
    @(negedge clk);
    for (int c = 0; c <= bp; c++) begin
      if (c > 0) @(negedge clk);
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_result", 32'(rsp_result), 32'(e[7:0]));
      chk("rsp_id", 32'(rsp_id), 32'(g));
      chk("resp_ready", 32'(req_ready), 32'd0);
`ifdef ALU_FLAGS_EN
      chk("rsp_carry", 32'(rsp_carry), 32'(e[8]));
      chk("rsp_zero", 32'(rsp_zero), 32'(e[7:0] == 8'd0));
`endif
      if (c == bp) rsp_ready = 1'b1;
    end
    @(negedge clk);
    chk("idle_valid", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [N-1:0] v;
    rst = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    scramble();
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    rst = 1'b0;
    last_g = N - 1;
    do_op('1, 0, 1'b0);
    repeat (4) do_op('1, 0, 1'b1);

    va[2] = 8'hF0; vb[2] = 8'h20; vo[2] = 3'b000;
    do_op(4'b0100, 0, 1'b0);
    va[1] = 8'h03; vb[1] = 8'h05; vo[1] = 3'b001;
    do_op(4'b0010, 0, 1'b0);
    va[3] = 8'h5A; vo[3] = 3'b101;
    do_op(4'b1000, 0, 1'b0);
    vo[0] = 3'b111;
    do_op(4'b0001, 0, 1'b0);
    va[1] = 8'hFF; vb[1] = 8'h01; vo[1] = 3'b000;
    do_op(4'b1111, 5, 1'b0);

    req_valid = '1;
    #1;
    chk("mid_grant", 32'(req_ready), 32'(N'(1) << ref_pick('1)));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_valid", 32'(rsp_valid), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_g = N - 1;
    do_op('1, 0, 1'b0);

    for (int it = 0; it < 60; it++) begin
      v = N'($urandom_range(0, 15));
      if (v == '0) begin
        req_valid = '0;
        #1;
        chk("none_ready", 32'(req_ready), 32'd0);
        chk("none_busy", 32'(busy), 32'd0);
        @(negedge clk);
      end else begin
        do_op(v, $urandom_range(0, 3), 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
